clip_monitor: RTL and testbench
===============================

Name: clip_monitor

Overview:
- Consumes the per-sample overflow flag from the mix-bus saturation stage.
- The mix engine runs time-multiplexed (TDM) channels; this block accumulates clip events per channel.
- Per channel it keeps a sticky clip bit, a saturating clip-event count, and a front-panel clip LED with a hold time measured in frames.
- Control software reads and clears the counters through a single-cycle request/response port.

Parameters:
- NUM_CHANNELS, 16, number of TDM channels monitored.
- CHAN_WIDTH, 4, width of the channel index; must satisfy 2**CHAN_WIDTH >= NUM_CHANNELS.
- COUNT_WIDTH, 8, width of each saturating clip-event counter.
- HOLD_FRAMES, 4800, number of frames the LED stays lit after the last clip (100 ms at 48 kHz).
- HOLD_WIDTH, 13, width of each hold timer; must satisfy 2**HOLD_WIDTH > HOLD_FRAMES.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a saturated sample is present this cycle.
- in_chan, input, CHAN_WIDTH, channel index of that sample.
- in_overflow, input, 1, saturation occurred on that sample.
- frame_strobe, input, 1, one-cycle pulse once per audio frame.
- clip_led, output, NUM_CHANNELS, bit c is high while channel c's hold timer is nonzero.
- rd_req, input, 1, read request.
- rd_chan, input, CHAN_WIDTH, channel to read.
- rd_clear, input, 1, clear the sticky bit and count of rd_chan as part of the read.
- rd_valid, output, 1, one-cycle response pulse.
- rd_count, output, COUNT_WIDTH, clip count returned.
- rd_sticky, output, 1, sticky clip bit returned.

Behaviour:
- Reset: asserting reset_n low asynchronously zeroes every count, sticky bit and hold timer. It also forces clip_led=0, rd_valid=0, rd_count=0 and rd_sticky=0. Reset mid-read drops the pending response, so no rd_valid follows release.
- Clip event: in_valid && in_overflow && in_chan < NUM_CHANNELS. On the next edge for channel c=in_chan:
  - sticky[c] is set to 1.
  - count[c] is incremented, saturating at 2**COUNT_WIDTH-1 (it never wraps to 0).
  - hold[c] is loaded with HOLD_FRAMES.
- Out-of-range channel: if in_chan >= NUM_CHANNELS, the sample is ignored with no state change.
- Hold timers:
  - On frame_strobe, every nonzero hold[c] decrements by 1.
  - A hold timer at 0 stays at 0.
  - If a clip event on c coincides with frame_strobe, the reload wins: hold[c]=HOLD_FRAMES and there is no decrement.
- clip_led[c]:
  - Equals (hold[c] != 0), decoded from registered state.
  - Rises one cycle after the event.
  - Falls one cycle after the frame_strobe that brings hold[c] to 0, i.e. the HOLD_FRAMES-th strobe after the last event.
- Read timing:
  - rd_req is sampled at cycle N.
  - At cycle N+1, rd_valid=1 for exactly one cycle.
  - rd_count and rd_sticky carry the values of count[rd_chan] and sticky[rd_chan] as they stood during cycle N, i.e. before any cycle-N update.
- Read throughput: a read may be issued every cycle, with fully pipelined back-to-back responses. rd_count and rd_sticky hold their last value while rd_valid=0.
- rd_clear:
  - At the cycle-N edge, count[rd_chan] and sticky[rd_chan] are set to 0.
  - rd_clear does not affect hold timers or clip_led.
  - rd_clear is ignored when rd_req=0.
- Clear coinciding with a clip event on the same channel in cycle N:
  - The event is not lost: the result is count=1 and sticky=1.
  - The returned data is the pre-clear value.
- Read coinciding with an event but without clear: the returned data excludes the cycle-N event, and the stored state includes it.
- rd_chan >= NUM_CHANNELS: rd_valid still pulses, with rd_count=0 and rd_sticky=0. No state changes, even with rd_clear set.
- Independence: all channels update independently; an event on one channel never alters another.

Test Plan:
- Reset, then a single event on ch 3 -> clip_led[3] rises on the next cycle. Read ch3 -> rd_valid one cycle later, rd_count=1, rd_sticky=1; all other LEDs stay 0.
- 300 events on ch 5 with COUNT_WIDTH=8 -> read returns rd_count=255 (saturated, not 44). A read with rd_clear=1, then a second read -> rd_count=0, rd_sticky=0.
- Event on ch 0 with HOLD_FRAMES=4, then 4 frame_strobes -> LED high through the 3rd strobe, low one cycle after the 4th. Repeat with an event coinciding with the 2nd strobe -> timer reloads to 4 and the LED stays high for 4 more strobes.
- Clip event on ch 7 in the same cycle as rd_req/rd_clear on ch 7, with prior count=10 -> response rd_count=10, rd_sticky=1; a following read gives count=1, sticky=1.
- in_chan=15 with NUM_CHANNELS=12, and rd_req on rd_chan=14 with rd_clear -> no state change anywhere; response rd_count=0, rd_sticky=0, rd_valid still pulses.
- Assert reset_n low the cycle after rd_req while LEDs are lit -> all outputs 0 immediately, no rd_valid after release, all counts read 0.

Source files
------------

// File: rtl/clip_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : clip_monitor_if
// Brief    : Clip-event input, LED output and read/clear port of clip_monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface clip_monitor_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int CHAN_WIDTH   = 4,
    parameter int COUNT_WIDTH  = 8
) ();
    logic                    in_valid;
    logic [CHAN_WIDTH-1:0]   in_chan;
    logic                    in_overflow;
    logic                    frame_strobe;
    logic [NUM_CHANNELS-1:0] clip_led;
    logic                    rd_req;
    logic [CHAN_WIDTH-1:0]   rd_chan;
    logic                    rd_clear;
    logic                    rd_valid;
    logic [COUNT_WIDTH-1:0]  rd_count;
    logic                    rd_sticky;

    modport master (
        output in_valid, in_chan, in_overflow, frame_strobe,
        output rd_req, rd_chan, rd_clear,
        input  clip_led, rd_valid, rd_count, rd_sticky
    );

    modport slave (
        input  in_valid, in_chan, in_overflow, frame_strobe,
        input  rd_req, rd_chan, rd_clear,
        output clip_led, rd_valid, rd_count, rd_sticky
    );
endinterface
`default_nettype wire

// File: rtl/clip_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clip_monitor
// Brief    : Per-channel sticky clip flag, saturating clip counter and LED hold.
// Revision : 1.0 - initial release
// ============================================================================
module clip_monitor #(
    parameter int NUM_CHANNELS = 16,
    parameter int CHAN_WIDTH   = 4,
    parameter int COUNT_WIDTH  = 8,
    parameter int HOLD_FRAMES  = 4800,
    parameter int HOLD_WIDTH   = 13
) (
    input  wire             clk,
    input  wire             reset_n,
    clip_monitor_if.slave   bus
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = {COUNT_WIDTH{1'b1}};
    localparam logic [HOLD_WIDTH-1:0]  c_hold_load = HOLD_WIDTH'(HOLD_FRAMES);

    logic [COUNT_WIDTH-1:0]  r_count [NUM_CHANNELS];
    logic [HOLD_WIDTH-1:0]   r_hold  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_sticky;

    logic                    r_rd_valid;
    logic [COUNT_WIDTH-1:0]  r_rd_count;
    logic                    r_rd_sticky;

    logic [NUM_CHANNELS-1:0] w_evt;
    logic [NUM_CHANNELS-1:0] w_clr;
    logic [NUM_CHANNELS-1:0] w_led;
    logic [COUNT_WIDTH-1:0]  w_rd_count;
    logic                    w_rd_sticky;

    // Channel decode; indices at or above NUM_CHANNELS match nothing.
    always_comb begin
        w_evt       = '0;
        w_clr       = '0;
        w_led       = '0;
        w_rd_count  = '0;
        w_rd_sticky = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_evt[c] = bus.in_valid && bus.in_overflow && (bus.in_chan == CHAN_WIDTH'(c));
            w_clr[c] = bus.rd_req && bus.rd_clear && (bus.rd_chan == CHAN_WIDTH'(c));
            w_led[c] = (r_hold[c] != '0);
            if (bus.rd_chan == CHAN_WIDTH'(c)) begin
                w_rd_count  = r_count[c];
                w_rd_sticky = r_sticky[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_count[c] <= '0;
                r_hold[c]  <= '0;
            end
            r_sticky <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                // A clear in the same cycle as an event restarts from that event.
                if (w_clr[c]) begin
                    r_count[c]  <= w_evt[c] ? COUNT_WIDTH'(1) : '0;
                    r_sticky[c] <= w_evt[c];
                end else if (w_evt[c]) begin
                    r_sticky[c] <= 1'b1;
                    if (r_count[c] != c_count_max) begin
                        r_count[c] <= r_count[c] + COUNT_WIDTH'(1);
                    end
                end

                if (w_evt[c]) begin
                    r_hold[c] <= c_hold_load;
                end else if (bus.frame_strobe && (r_hold[c] != '0)) begin
                    r_hold[c] <= r_hold[c] - HOLD_WIDTH'(1);
                end
            end
        end
    end

    // Response carries pre-update state; data holds while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid  <= 1'b0;
            r_rd_count  <= '0;
            r_rd_sticky <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_rd_count  <= w_rd_count;
                r_rd_sticky <= w_rd_sticky;
            end
        end
    end

    assign bus.clip_led  = w_led;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_count  = r_rd_count;
    assign bus.rd_sticky = r_rd_sticky;

endmodule
`default_nettype wire

// File: tb/tb_clip_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clip_monitor
// Brief    : Directed stimulus with a queue-based scoreboard for clip_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clip_monitor;

    localparam int NUM_CHANNELS = 12;
    localparam int CHAN_WIDTH   = 4;
    localparam int COUNT_WIDTH  = 8;
    localparam int HOLD_FRAMES  = 4;
    localparam int HOLD_WIDTH   = 3;

    typedef struct {
        int                     chan;
        logic [COUNT_WIDTH-1:0] cnt;
        logic                   st;
        int                     due;
    } exp_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   cyc;
    exp_t sb[$];

    clip_monitor_if #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) bus ();

    clip_monitor #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .HOLD_WIDTH   (HOLD_WIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every rd_valid must match the oldest outstanding read, on time.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.rd_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: rd_valid=1 count=%0d sticky=%0d at cycle %0d, expected no response",
                             bus.rd_count, bus.rd_sticky, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.rd_count !== e.cnt || bus.rd_sticky !== e.st || cyc != e.due) begin
                        miscompares++;
                        $display("FAIL rd ch%0d: count=%0d sticky=%0d cycle=%0d, expected count=%0d sticky=%0d cycle=%0d",
                                 e.chan, bus.rd_count, bus.rd_sticky, cyc, e.cnt, e.st, e.due);
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_missing ch%0d: no rd_valid by cycle %0d, expected at cycle %0d",
                         sb[0].chan, cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.in_overflow  = 1'b0;
        bus.frame_strobe = 1'b0;
        bus.rd_req       = 1'b0;
        bus.rd_clear     = 1'b0;
    endtask

    task automatic ev(input int ch);
        bus.in_valid    = 1'b1;
        bus.in_overflow = 1'b1;
        bus.in_chan     = CHAN_WIDTH'(ch);
    endtask

    // Issue a read for the coming edge and queue its expected response.
    task automatic rd(input int ch, input logic clr, input int ecnt, input logic est);
        exp_t e;
        bus.rd_req   = 1'b1;
        bus.rd_chan  = CHAN_WIDTH'(ch);
        bus.rd_clear = clr;
        e.chan = ch;
        e.cnt  = COUNT_WIDTH'(ecnt);
        e.st   = est;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset_n          = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_chan      = '0;
        bus.in_overflow  = 1'b0;
        bus.frame_strobe = 1'b0;
        bus.rd_req       = 1'b0;
        bus.rd_chan      = '0;
        bus.rd_clear     = 1'b0;

        step(); step();
        check("reset_led",       32'(bus.clip_led),  32'h0);
        check("reset_rd_valid",  32'(bus.rd_valid),  32'h0);
        check("reset_rd_count",  32'(bus.rd_count),  32'h0);
        check("reset_rd_sticky", 32'(bus.rd_sticky), 32'h0);
        reset_n = 1'b1;

        // Single event on ch3
        ev(3); step();
        check("led_ch3_rise", 32'(bus.clip_led), 32'h008);
        rd(3, 1'b0, 1, 1'b1); step(); step();
        check("led_only_ch3", 32'(bus.clip_led), 32'h008);

        // Saturation on ch5, then clear-on-read
        for (int i = 0; i < 300; i++) begin
            ev(5); step();
        end
        rd(5, 1'b1, 255, 1'b1); step();
        rd(5, 1'b0, 0, 1'b0);   step(); step();

        // Hold timer on ch0 (ch3/ch5 timers expire with the same strobes)
        ev(0); step();
        check("led_ch0_rise", 32'(bus.clip_led[0]), 32'h1);
        for (int s = 1; s <= 4; s++) begin
            bus.frame_strobe = 1'b1; step();
            check($sformatf("led_ch0_strobe%0d", s), 32'(bus.clip_led[0]), (s < 4) ? 32'h1 : 32'h0);
        end
        check("led_all_off", 32'(bus.clip_led), 32'h0);

        // Event coinciding with the 2nd strobe reloads the timer
        ev(0); step();
        bus.frame_strobe = 1'b1; step();
        bus.frame_strobe = 1'b1; ev(0); step();
        check("led_ch0_reload", 32'(bus.clip_led[0]), 32'h1);
        for (int s = 1; s <= 4; s++) begin
            bus.frame_strobe = 1'b1; step();
            check($sformatf("led_ch0_reload_strobe%0d", s), 32'(bus.clip_led[0]), (s < 4) ? 32'h1 : 32'h0);
        end

        // Clear coinciding with an event on ch7 (prior count 10)
        for (int i = 0; i < 10; i++) begin
            ev(7); step();
        end
        ev(7); rd(7, 1'b1, 10, 1'b1); step();
        rd(7, 1'b0, 1, 1'b1); step(); step();

        // Out-of-range event and read-with-clear
        ev(15); rd(14, 1'b1, 0, 1'b0); step(); step();
        check("led_oor_unchanged", 32'(bus.clip_led), 32'h080);
        rd(7, 1'b0, 1, 1'b1); step();
        rd(5, 1'b0, 0, 1'b0); step(); step();

        // Reset while a read is pending and LEDs are lit; response is dropped
        ev(3); step();
        check("led_before_reset", 32'(bus.clip_led), 32'h088);
        bus.rd_req  = 1'b1;
        bus.rd_chan = CHAN_WIDTH'(3);
        #2 reset_n = 1'b0;
        #1;
        check("async_led",       32'(bus.clip_led),  32'h0);
        check("async_rd_valid",  32'(bus.rd_valid),  32'h0);
        check("async_rd_count",  32'(bus.rd_count),  32'h0);
        check("async_rd_sticky", 32'(bus.rd_sticky), 32'h0);
        step(); step();
        reset_n = 1'b1;
        step(); step();
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd(c, 1'b0, 0, 1'b0); step();
        end
        step(); step(); step();
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
